// File: rtl/execute_muldiv_if.sv
// ----------------------------------------------------------------------------
// execute_muldiv_if
//   Bundles the ID/EX request side and the EX/MEM result side of the
//   multi-cycle multiply/divide unit.
//   master : pipeline side (drives the request and stall_MEM, observes results)
//   slave  : the execute_muldiv unit
//   Request : start_IDEX, op_IDEX, A_IDEX, B_IDEX, WrR_IDEX, RegWrite_IDEX
//   Flow    : ready_IDEX, stall_IDEX (unit -> front end), stall_MEM (MEM -> unit)
//   Result  : Result_EXMEM, WrR_EXMEM, RegWrite_EXMEM, valid_EXMEM, divz_EXMEM
// ----------------------------------------------------------------------------
interface execute_muldiv_if #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
);
    logic             start_IDEX;
    logic [1:0]       op_IDEX;
    logic [WIDTH-1:0] A_IDEX;
    logic [WIDTH-1:0] B_IDEX;
    logic [REGW-1:0]  WrR_IDEX;
    logic             RegWrite_IDEX;
    logic             ready_IDEX;
    logic             stall_IDEX;
    logic             stall_MEM;
    logic [WIDTH-1:0] Result_EXMEM;
    logic [REGW-1:0]  WrR_EXMEM;
    logic             RegWrite_EXMEM;
    logic             valid_EXMEM;
    logic             divz_EXMEM;

    modport master (
        output start_IDEX, op_IDEX, A_IDEX, B_IDEX, WrR_IDEX, RegWrite_IDEX, stall_MEM,
        input  ready_IDEX, stall_IDEX, Result_EXMEM, WrR_EXMEM, RegWrite_EXMEM,
               valid_EXMEM, divz_EXMEM
    );

    modport slave (
        input  start_IDEX, op_IDEX, A_IDEX, B_IDEX, WrR_IDEX, RegWrite_IDEX, stall_MEM,
        output ready_IDEX, stall_IDEX, Result_EXMEM, WrR_EXMEM, RegWrite_EXMEM,
               valid_EXMEM, divz_EXMEM
    );
endinterface

// File: rtl/execute_muldiv.sv
// ----------------------------------------------------------------------------
// execute_muldiv
//   Multi-cycle unsigned multiply/divide unit for the EX stage. Handles MUL,
//   MULHU, DIVU and REMU, one bit per cycle (WIDTH cycles from accept to a
//   valid result), and holds its registered EX/MEM result under stall_MEM.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - execute_muldiv_if.slave (request, flow control, result)
// ----------------------------------------------------------------------------
module execute_muldiv #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    execute_muldiv_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;    // multiplicand (A) for multiply, divisor (B) for divide
    logic [2*WIDTH-1:0] acc;       // {partial product, multiplier bits not yet consumed}
    logic [WIDTH:0]     prem;      // partial remainder
    logic [WIDTH-1:0]   quo;       // dividend bits shift out at the top, quotient bits shift in
    logic [REGW-1:0]    wrr_q;
    logic               regwrite_q;
    logic               divz_q;

    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH+1:0]   diff;
    logic               no_borrow;
    logic [WIDTH:0]     prem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    function automatic logic [WIDTH-1:0] pick_result(
        input logic [1:0]         op,
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   q,
        input logic [WIDTH-1:0]   r
    );
        case (op)
            2'b00:   return p[WIDTH-1:0];
            2'b01:   return p[2*WIDTH-1:WIDTH];
            2'b10:   return q;
            default: return r;
        endcase
    endfunction

    // One iteration of both algorithms; only the one matching op_q is used.
    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the whole accumulator right by one.
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        acc_nxt = {psum, acc[WIDTH-1:1]};
        // Restoring division: the top bit of diff is the borrow. A zero divisor
        // never borrows, so the quotient fills with ones and the remainder is A.
        trial     = {prem, quo[WIDTH-1]};
        diff      = trial - {2'b00, opnd_q};
        no_borrow = ~diff[WIDTH+1];
        prem_nxt  = no_borrow ? diff[WIDTH:0] : trial[WIDTH:0];
        quo_nxt   = {quo[WIDTH-2:0], no_borrow};
    end

    assign bus.ready_IDEX = (state == IDLE);
    // The accepting cycle stalls too, so ID/EX keeps the following instruction.
    assign bus.stall_IDEX = (state != IDLE) | bus.start_IDEX;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            op_q               <= '0;
            opnd_q             <= '0;
            acc                <= '0;
            prem               <= '0;
            quo                <= '0;
            wrr_q              <= '0;
            regwrite_q         <= 1'b0;
            divz_q             <= 1'b0;
            bus.Result_EXMEM   <= '0;
            bus.WrR_EXMEM      <= '0;
            bus.RegWrite_EXMEM <= 1'b0;
            bus.valid_EXMEM    <= 1'b0;
            bus.divz_EXMEM     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_IDEX) begin
                        op_q       <= bus.op_IDEX;
                        opnd_q     <= bus.op_IDEX[1] ? bus.B_IDEX : bus.A_IDEX;
                        acc        <= {{WIDTH{1'b0}}, bus.B_IDEX};
                        prem       <= '0;
                        quo        <= bus.A_IDEX;
                        wrr_q      <= bus.WrR_IDEX;
                        regwrite_q <= bus.RegWrite_IDEX;
                        divz_q     <= bus.op_IDEX[1] & (bus.B_IDEX == '0);
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_nxt;
                    prem <= prem_nxt;
                    quo  <= quo_nxt;
                    cnt  <= cnt + CW'(1);
                    // Final iteration: register the result straight from the
                    // next-state values so valid appears exactly WIDTH edges in.
                    if (cnt == LAST) begin
                        state              <= DONE;
                        bus.Result_EXMEM   <= pick_result(op_q, acc_nxt, quo_nxt,
                                                          prem_nxt[WIDTH-1:0]);
                        bus.WrR_EXMEM      <= wrr_q;
                        bus.RegWrite_EXMEM <= regwrite_q;
                        bus.divz_EXMEM     <= divz_q;
                        bus.valid_EXMEM    <= 1'b1;
                    end
                end
                DONE: begin
                    // Result and destination hold after handoff; only the
                    // qualifiers drop.
                    if (!bus.stall_MEM) begin
                        state              <= IDLE;
                        bus.valid_EXMEM    <= 1'b0;
                        bus.RegWrite_EXMEM <= 1'b0;
                        bus.divz_EXMEM     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
